// File: rtl/alu_pkg.sv
// Shared opcode encoding, Hamming(16,11) position map and codeword helpers for the datapath ALU.
package alu_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CW_W   = 16;
    localparam int unsigned DW     = 11;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned PTN_W  = 5;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned SYN_W  = 4;
    localparam int unsigned SRC_W  = 12;

    typedef enum logic [OP_W-1:0] {
        INC = 4'b0100,
        HGP = 4'b0111,
        HEL = 4'b1000,
        HEM = 4'b1001,
        HEP = 4'b1010,
        HCL = 4'b1011,
        HCM = 4'b1100,
        POB = 4'b1101,
        PTB = 4'b1110,
        APC = 4'b1111
    } alu_op_e;

    // Codeword position of data bit Di
    localparam int unsigned DATA_POS [DW] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

    // s[k] = XOR of c at every position 1..15 whose index has bit k set
    function automatic logic [SYN_W-1:0] ham_syndrome(input logic [CW_W-1:0] c);
        logic [SYN_W-1:0] s;
        s = '0;
        for (int p = 1; p < int'(CW_W); p++) begin
            for (int k = 0; k < int'(SYN_W); k++) begin
                if (((p >> k) & 1) == 1) begin
                    s[2'(k)] ^= c[4'(p)];
                end
            end
        end
        return s;
    endfunction

    function automatic logic [CW_W-1:0] place_data(input logic [DW-1:0] d);
        logic [CW_W-1:0] c;
        c = '0;
        for (int i = 0; i < int'(DW); i++) begin
            c[4'(DATA_POS[i])] = d[4'(i)];
        end
        return c;
    endfunction

    function automatic logic [DW-1:0] extract_data(input logic [CW_W-1:0] c);
        logic [DW-1:0] d;
        d = '0;
        for (int i = 0; i < int'(DW); i++) begin
            d[4'(i)] = c[4'(DATA_POS[i])];
        end
        return d;
    endfunction

endpackage

// File: rtl/alu_ptn_count.sv
// Counts 5-bit pattern matches at window offsets 4..7 of a 12-bit source.
module alu_ptn_count
    import alu_pkg::*;
(
    input  logic [SRC_W-1:0] src,
    input  logic [PTN_W-1:0] ptn,
    output logic [CNT_W-1:0] cnt_c
);

    logic unused_c;
    assign unused_c = ^src[3:0];

    always_comb begin
        cnt_c = '0;
        for (int i = 4; i < 8; i++) begin
            if (PTN_W'(src >> i) == ptn) begin
                cnt_c = cnt_c + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/alu.sv
// Combinational 8-bit datapath ALU (add/inc, Hamming encode/decode helpers, pattern counts) with a registered result copy.
module alu
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] rf_reg_out,
    input  logic [DATA_W-1:0] rpct,
    input  logic [DATA_W-1:0] rlsb,
    input  logic [DATA_W-1:0] rmsb,
    input  logic [DATA_W-1:0] rptn,
    input  logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_out,
    output logic [DATA_W-1:0] alu_out_r
);

    logic [DW-1:0]     data_w;
    logic [CW_W-1:0]   cw;
    logic [CW_W-1:0]   cw_fix;
    logic [DW-1:0]     d_fix;
    logic [SYN_W-1:0]  par_s;
    logic [SYN_W-1:0]  chk_s;
    logic [SYN_W-1:0]  flip_pos;
    logic              dbl_err;
    logic [CNT_W-1:0]  pob_cnt;
    logic [CNT_W-1:0]  ptb_cnt;
    logic [DATA_W-1:0] alu_out_c;
    logic [DATA_W-1:0] alu_out_r_d;
    logic [DATA_W-1:0] alu_out_r_q;
    logic              unused_c;

    assign unused_c = ^{rpct[7:5], rptn[2:0]};

    // Single-byte pattern windows sit at offsets 4..7 when the byte is placed in the top of the source
    alu_ptn_count u_pob (
        .src   ({rlsb, 4'b0000}),
        .ptn   (rptn[7:3]),
        .cnt_c (pob_cnt)
    );

    // Stream {rlsb, rmsb}: windows starting at bits 4..7 straddle the byte boundary
    alu_ptn_count u_ptb (
        .src   ({rlsb[3:0], rmsb}),
        .ptn   (rptn[7:3]),
        .cnt_c (ptb_cnt)
    );

    always_comb begin
        data_w   = {rmsb[2:0], rlsb};
        cw       = {rmsb, rlsb};
        par_s    = ham_syndrome(place_data(data_w));
        chk_s    = ham_syndrome(cw);
        flip_pos = rpct[4:1];
        dbl_err  = (flip_pos != '0) && !rpct[0];
        cw_fix   = cw;
        if (flip_pos != '0) begin
            cw_fix[flip_pos] = ~cw[flip_pos];
        end
        d_fix     = extract_data(cw_fix);
        alu_out_c = '0;
        case (alu_op)
            INC:     alu_out_c = rf_reg_out + DATA_W'(1);
            APC:     alu_out_c = rf_reg_out + rpct;
            HGP:     alu_out_c = {3'b000, par_s, (^data_w) ^ (^par_s)};
            HEL:     alu_out_c = {data_w[3], data_w[2], data_w[1], rpct[3],
                                  data_w[0], rpct[2], rpct[1], rpct[0]};
            HEM:     alu_out_c = {data_w[10:4], rpct[4]};
            HEP:     alu_out_c = {3'b000, chk_s, ^cw};
            HCL:     alu_out_c = d_fix[7:0];
            HCM:     alu_out_c = {dbl_err, 4'b0000, d_fix[10:8]};
            POB:     alu_out_c = DATA_W'(pob_cnt);
            PTB:     alu_out_c = DATA_W'(ptb_cnt);
            default: alu_out_c = '0;
        endcase
    end

    assign alu_out_r_d = alu_out_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_out_r_q <= '0;
        end else begin
            alu_out_r_q <= alu_out_r_d;
        end
    end

    assign alu_out   = alu_out_c;
    assign alu_out_r = alu_out_r_q;

endmodule

// File: tb/tb_alu.sv
// Directed scoreboard bench for alu: checks the combinational result and its registered copy.
module tb_alu;

    logic       clk;
    logic       reset;
    logic [7:0] rf_reg_out;
    logic [7:0] rpct;
    logic [7:0] rlsb;
    logic [7:0] rmsb;
    logic [7:0] rptn;
    logic [3:0] alu_op;
    logic [7:0] alu_out;
    logic [7:0] alu_out_r;

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_tests;
    int   n_fail;

    alu dut (
        .clk        (clk),
        .reset      (reset),
        .rf_reg_out (rf_reg_out),
        .rpct       (rpct),
        .rlsb       (rlsb),
        .rmsb       (rmsb),
        .rptn       (rptn),
        .alu_op     (alu_op),
        .alu_out    (alu_out),
        .alu_out_r  (alu_out_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic drive(input logic [3:0] op, input logic [7:0] rf, input logic [7:0] pct,
                         input logic [7:0] lsb, input logic [7:0] msb, input logic [7:0] ptn,
                         input logic [7:0] exp, input string tag);
        exp_t e;
        @(negedge clk);
        alu_op     = op;
        rf_reg_out = rf;
        rpct       = pct;
        rlsb       = lsb;
        rmsb       = msb;
        rptn       = ptn;
        e.tag      = tag;
        e.exp      = exp;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t       e;
        logic [7:0] exp_r;
        #1;
        n_tests++;
        assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL scoreboard: observed empty queue, required one pending entry");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            n_tests++;
            assert (alu_out === e.exp) else begin
                n_fail++;
                $error("FAIL %s alu_out: observed %b required %b", e.tag, alu_out, e.exp);
            end
            exp_r = reset ? 8'h00 : e.exp;
            @(posedge clk);
            #1;
            n_tests++;
            assert (alu_out_r === exp_r) else begin
                n_fail++;
                $error("FAIL %s alu_out_r: observed %b required %b", e.tag, alu_out_r, exp_r);
            end
        end
    endtask

    task automatic step(input logic [3:0] op, input logic [7:0] rf, input logic [7:0] pct,
                        input logic [7:0] lsb, input logic [7:0] msb, input logic [7:0] ptn,
                        input logic [7:0] exp, input string tag);
        drive(op, rf, pct, lsb, msb, ptn, exp, tag);
        check_out();
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        reset      = 1'b1;
        rf_reg_out = '0;
        rpct       = '0;
        rlsb       = '0;
        rmsb       = '0;
        rptn       = '0;
        alu_op     = '0;

        // Reset held: combinational path still live, register forced to zero
        step(4'b0100, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, "reset_inc");
        reset = 1'b0;

        step(4'b0100, 8'd0,   8'd0, 8'd0, 8'd0, 8'd0, 8'd1,   "inc_0");
        step(4'b0100, 8'd127, 8'd0, 8'd0, 8'd0, 8'd0, 8'd128, "inc_127");
        step(4'b0100, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0,   "inc_255");
        step(4'b1111, 8'd4,   8'd8, 8'd0, 8'd0, 8'd0, 8'd12,  "apc_4_8");
        step(4'b1111, 8'd200, 8'd100, 8'd0, 8'd0, 8'd0, 8'd44, "apc_wrap");

        step(4'b0111, 8'd0, 8'd0,         8'b10101001, 8'b00000111, 8'd0, 8'b00011100, "hgp_a");
        step(4'b1000, 8'd0, 8'b00011100,  8'b10101001, 8'b00000111, 8'd0, 8'b10011100, "hel_a");
        step(4'b1001, 8'd0, 8'b00011100,  8'b10101001, 8'b00000111, 8'd0, 8'b11110101, "hem_a");
        step(4'b0111, 8'd0, 8'd0,         8'b11111111, 8'b00000101, 8'd0, 8'b00000011, "hgp_b");
        step(4'b1000, 8'd0, 8'b00000011,  8'b11111111, 8'b00000101, 8'd0, 8'b11101011, "hel_b");
        step(4'b1001, 8'd0, 8'b00000011,  8'b11111111, 8'b00000101, 8'd0, 8'b10111110, "hem_b");

        step(4'b1010, 8'd0, 8'd0, 8'b10011100, 8'b11110101, 8'd0, 8'b00000000, "hep_clean");
        step(4'b1011, 8'd0, 8'd0, 8'b10011100, 8'b11110101, 8'd0, 8'b10101001, "hcl_clean");
        step(4'b1100, 8'd0, 8'd0, 8'b10011100, 8'b11110101, 8'd0, 8'b00000111, "hcm_clean");

        step(4'b1010, 8'd0, 8'd0,        8'b11010001, 8'b00110010, 8'd0, 8'b00011011, "hep_single");
        step(4'b1011, 8'd0, 8'b00011011, 8'b11010001, 8'b00110010, 8'd0, 8'b10011100, "hcl_single");
        step(4'b1100, 8'd0, 8'b00011011, 8'b11010001, 8'b00110010, 8'd0, 8'b00000000, "hcm_single");

        step(4'b1010, 8'd0, 8'd0,        8'b01000000, 8'b00000100, 8'd0, 8'b00011000, "hep_double");
        step(4'b1011, 8'd0, 8'b00011000, 8'b01000000, 8'b00000100, 8'd0, 8'b10100100, "hcl_double");
        step(4'b1100, 8'd0, 8'b00011000, 8'b01000000, 8'b00000100, 8'd0, 8'b10000000, "hcm_double");

        step(4'b1101, 8'd0, 8'd0, 8'b11011011, 8'b01111011, 8'b11011000, 8'd2, "pob_a");
        step(4'b1110, 8'd0, 8'd0, 8'b11011011, 8'b01111011, 8'b11011000, 8'd1, "ptb_a");
        step(4'b1101, 8'd0, 8'd0, 8'h00, 8'hFF, 8'h00, 8'd4, "pob_b");
        step(4'b1110, 8'd0, 8'd0, 8'h00, 8'hFF, 8'h00, 8'd0, "ptb_b");
        step(4'b1101, 8'd0, 8'd0, 8'hF0, 8'h0F, 8'h00, 8'd0, "pob_c");
        step(4'b1110, 8'd0, 8'd0, 8'hF0, 8'h0F, 8'h00, 8'd4, "ptb_c");

        step(4'b0000, 8'hAA, 8'h55, 8'hFF, 8'hFF, 8'hFF, 8'h00, "op_0000");
        step(4'b0101, 8'hAA, 8'h55, 8'hFF, 8'hFF, 8'hFF, 8'h00, "op_0101");
        step(4'b0110, 8'hAA, 8'h55, 8'hFF, 8'hFF, 8'hFF, 8'h00, "op_0110");

        // Reset asserted mid-run clears only the registered copy
        reset = 1'b1;
        step(4'b1111, 8'd4, 8'd8, 8'd0, 8'd0, 8'd0, 8'd12, "reset_mid");
        reset = 1'b0;
        step(4'b0100, 8'd9, 8'd0, 8'd0, 8'd0, 8'd0, 8'd10, "post_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
